// File: rtl/commit_rat.sv
// commit_rat: committed register alias table.
//   Accepts up to two in-order retirements per cycle, remaps the committed
//   arch->phys map, and queues each displaced physical register in a small
//   FIFO that drains to the physical free list over valid/ready.
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   commit_valid[1:0]           [0]=oldest slot, [1]=younger slot
//   commit_rd_arch_k/_phy_k     per-slot destination arch / phys register
//   commit_ready                FIFO has room for two pushes (registered count)
//   back_rat                    committed map, entry i at [i*PHY_WIDTH +: PHY_WIDTH]
//   free_valid/free_phy         FIFO head toward the free list
//   free_ready                  free list accepts free_phy this cycle
//   free_count                  FIFO occupancy
module commit_rat #(
  parameter int unsigned ARCH_REGS  = 32,
  parameter int unsigned PHY_WIDTH  = 6,
  parameter int unsigned FREE_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        commit_valid,
  input  logic [4:0]                        commit_rd_arch_0,
  input  logic [PHY_WIDTH-1:0]              commit_rd_phy_0,
  input  logic [4:0]                        commit_rd_arch_1,
  input  logic [PHY_WIDTH-1:0]              commit_rd_phy_1,
  output logic                              commit_ready,
  output logic [PHY_WIDTH*ARCH_REGS-1:0]    back_rat,
  output logic                              free_valid,
  output logic [PHY_WIDTH-1:0]              free_phy,
  input  logic                              free_ready,
  output logic [$clog2(FREE_DEPTH):0]       free_count
);

  localparam int unsigned PTR_W = $clog2(FREE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PHY_WIDTH-1:0] table_q [ARCH_REGS];
  logic [PHY_WIDTH-1:0] table_d [ARCH_REGS];
  logic [PHY_WIDTH-1:0] mem_q   [FREE_DEPTH];
  logic [PHY_WIDTH-1:0] mem_d   [FREE_DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 acc0, acc1, do0, do1, pop;
  logic [PHY_WIDTH-1:0] free0, free1;
  logic [PTR_W-1:0]     wptr;
  logic [1:0]           n_push;

  // Ready depends only on the registered count, so free_ready never reaches it.
  assign commit_ready = (count_q <= CNT_W'(FREE_DEPTH - 2));
  assign free_valid   = (count_q != '0);
  assign free_phy     = mem_q[head_q];
  assign free_count   = count_q;

  // Flat view of the committed map.
  always_comb begin
    back_rat = '0;
    for (int i = 0; i < int'(ARCH_REGS); i++) begin
      back_rat[i*PHY_WIDTH +: PHY_WIDTH] = table_q[i];
    end
  end

  // Acceptance, remap, displaced-register capture and FIFO bookkeeping.
  always_comb begin
    table_d = table_q;
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wptr    = tail_q;

    // Slot1 alone (2'b10) is illegal and dropped.
    acc0 = commit_valid[0] && commit_ready;
    acc1 = commit_valid[1] && commit_valid[0] && commit_ready;
    do0  = acc0 && (commit_rd_arch_0 != '0);
    do1  = acc1 && (commit_rd_arch_1 != '0);

    // Slot1 displaces slot0's new mapping when both target the same register.
    free0 = table_q[commit_rd_arch_0];
    free1 = (do0 && (commit_rd_arch_1 == commit_rd_arch_0)) ? commit_rd_phy_0
                                                             : table_q[commit_rd_arch_1];

    if (do0) table_d[commit_rd_arch_0] = commit_rd_phy_0;
    if (do1) table_d[commit_rd_arch_1] = commit_rd_phy_1;

    if (do0) begin
      mem_d[wptr] = free0;
      wptr        = wptr + PTR_W'(1);
    end
    if (do1) begin
      mem_d[wptr] = free1;
      wptr        = wptr + PTR_W'(1);
    end
    tail_d = wptr;

    pop = free_valid && free_ready;
    if (pop) head_d = head_q + PTR_W'(1);

    n_push  = {1'b0, do0} + {1'b0, do1};
    count_d = count_q + CNT_W'(n_push) - CNT_W'(pop);
  end

  // State registers; reset restores the identity map and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) begin
        table_q[i] <= PHY_WIDTH'(i);
      end
      for (int j = 0; j < int'(FREE_DEPTH); j++) begin
        mem_q[j] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      table_q <= table_d;
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_commit_rat.sv
// tb_commit_rat: randomized + directed bench for commit_rat against a
// sequential-retirement model (arch map array + freed-register queue).
module tb_commit_rat;

  localparam int unsigned AR = 32;
  localparam int unsigned PW = 6;
  localparam int unsigned FD = 8;
  localparam int unsigned BW = AR * PW;

  logic          clk, rst;
  logic [1:0]    commit_valid;
  logic [4:0]    commit_rd_arch_0, commit_rd_arch_1;
  logic [PW-1:0] commit_rd_phy_0, commit_rd_phy_1;
  logic          commit_ready;
  logic [BW-1:0] back_rat;
  logic          free_valid;
  logic [PW-1:0] free_phy;
  logic          free_ready;
  logic [3:0]    free_count;

  commit_rat #(.ARCH_REGS(AR), .PHY_WIDTH(PW), .FREE_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid),
    .commit_rd_arch_0(commit_rd_arch_0), .commit_rd_phy_0(commit_rd_phy_0),
    .commit_rd_arch_1(commit_rd_arch_1), .commit_rd_phy_1(commit_rd_phy_1),
    .commit_ready(commit_ready), .back_rat(back_rat),
    .free_valid(free_valid), .free_phy(free_phy), .free_ready(free_ready),
    .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference state: committed map and queue of displaced registers.
  int mtbl [AR];
  int mq [$];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(AR); i++) mtbl[i] = i;
    mq.delete();
  endtask

  function automatic logic [BW-1:0] model_rat();
    logic [BW-1:0] v;
    for (int i = 0; i < int'(AR); i++) v[i*PW +: PW] = PW'(mtbl[i]);
    return v;
  endfunction

  function automatic logic [PW-1:0] rat_entry(input int i);
    logic [BW-1:0] v;
    v = back_rat;
    return v[i*PW +: PW];
  endfunction

  // Compares every visible output with the model.
  task automatic compare_model();
    int sz;
    sz = mq.size();
    chk("back_rat", back_rat, model_rat());
    chk("free_count", BW'(free_count), BW'(sz));
    chk("free_valid", BW'(free_valid), BW'(sz != 0));
    chk("commit_ready", BW'(commit_ready), BW'((int'(FD) - sz) >= 2));
    if (sz != 0) chk("free_phy", BW'(free_phy), BW'(mq[0]));
  endtask

  // Drives one cycle from a negedge, advances the model, checks at the next negedge.
  task automatic step(input logic [1:0] v, input int a0, input int p0,
                      input int a1, input int p1, input logic fr);
    bit ready;
    commit_valid     = v;
    commit_rd_arch_0 = 5'(a0);
    commit_rd_phy_0  = PW'(p0);
    commit_rd_arch_1 = 5'(a1);
    commit_rd_phy_1  = PW'(p1);
    free_ready       = fr;
    ready = (int'(FD) - mq.size()) >= 2;
    if (fr && mq.size() != 0) void'(mq.pop_front());
    if (ready && v[0]) begin
      if (a0 != 0) begin mq.push_back(mtbl[a0]); mtbl[a0] = p0; end
      if (v[1] && a1 != 0) begin mq.push_back(mtbl[a1]); mtbl[a1] = p1; end
    end
    @(posedge clk);
    @(negedge clk);
    commit_valid = 2'b00;
    free_ready   = 1'b0;
    compare_model();
  endtask

  initial begin
    logic [BW-1:0] ident;
    rst = 1'b1;
    commit_valid = '0; commit_rd_arch_0 = '0; commit_rd_arch_1 = '0;
    commit_rd_phy_0 = '0; commit_rd_phy_1 = '0; free_ready = 1'b0;
    model_reset();
    for (int i = 0; i < int'(AR); i++) ident[i*PW +: PW] = PW'(i);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    chk("rst_back_rat", back_rat, ident);
    chk("rst_free_valid", BW'(free_valid), BW'(0));
    chk("rst_commit_ready", BW'(commit_ready), BW'(1));
    chk("rst_free_count", BW'(free_count), BW'(0));
    compare_model();

    // Single commit rd=5 -> phy 40.
    step(2'b01, 5, 40, 0, 0, 1'b0);
    chk("c1_rat5", BW'(rat_entry(5)), BW'(40));
    chk("c1_free_phy", BW'(free_phy), BW'(5));
    chk("c1_count", BW'(free_count), BW'(1));

    // Dual commit to the same rd; FIFO order 5, 3, 33.
    step(2'b11, 3, 33, 3, 34, 1'b0);
    chk("dual_rat3", BW'(rat_entry(3)), BW'(34));
    chk("dual_count", BW'(free_count), BW'(3));
    step(2'b00, 0, 0, 0, 0, 1'b1);
    chk("pop_3", BW'(free_phy), BW'(3));
    step(2'b00, 0, 0, 0, 0, 1'b1);
    chk("pop_33", BW'(free_phy), BW'(33));
    step(2'b00, 0, 0, 0, 0, 1'b1);
    chk("drained", BW'(free_count), BW'(0));

    // rd=0 commit and illegal 2'b10 change nothing.
    step(2'b01, 0, 50, 0, 0, 1'b0);
    step(2'b10, 0, 0, 4, 60, 1'b0);
    chk("x0_rat4", BW'(rat_entry(4)), BW'(4));
    chk("x0_count", BW'(free_count), BW'(0));

    // Fill to 7 with free_ready low; further commits stall.
    for (int k = 1; k <= 7; k++) begin
      step(2'b01, k, 40 + k, 0, 0, 1'b0);
      if (k == 6) chk("fill6_ready", BW'(commit_ready), BW'(1));
    end
    chk("fill7_ready", BW'(commit_ready), BW'(0));
    step(2'b11, 8, 48, 9, 49, 1'b0);
    chk("stall_rat8", BW'(rat_entry(8)), BW'(8));
    chk("stall_count", BW'(free_count), BW'(7));
    step(2'b00, 0, 0, 0, 0, 1'b1);
    chk("drain_ready", BW'(commit_ready), BW'(1));
    chk("drain_head", BW'(free_phy), BW'(2));
    step(2'b00, 0, 0, 0, 0, 1'b1);
    step(2'b00, 0, 0, 0, 0, 1'b1);
    chk("steady_count4", BW'(free_count), BW'(4));

    // Dual commit with simultaneous pop: 4 + 2 - 1.
    step(2'b11, 10, 20, 11, 21, 1'b1);
    chk("push_pop_count", BW'(free_count), BW'(5));

    // Randomized traffic: a drain-heavy phase and a back-pressure phase.
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 300; n++) begin
        logic [1:0] v;
        int r;
        r = int'($urandom_range(0, 9));
        v = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : 2'b11;
        step(v, int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
             (r == 9) ? 0 : int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
             (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      end
    end

    // Asynchronous reset mid-stream.
    if (mq.size() == 0) step(2'b11, 12, 22, 13, 23, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_back_rat", back_rat, ident);
    chk("arst_count", BW'(free_count), BW'(0));
    chk("arst_free_valid", BW'(free_valid), BW'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compare_model();
    step(2'b01, 6, 60, 0, 0, 1'b0);
    chk("post_rst_free_phy", BW'(free_phy), BW'(6));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
